// File: rtl/status_reg_pkg.sv
// Shared definitions for the status register slice: SREG bit positions
// and the interrupt-enable tracker state encoding.
package status_reg_pkg;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;
  localparam int SREG_H = 5;
  localparam int SREG_T = 6;
  localparam int SREG_I = 7;

  localparam int ALU_FLAGS = 6;

  typedef enum logic [1:0] {
    IE_OFF = 2'd0,
    IE_ARM = 2'd1,
    IE_ON  = 2'd2
  } ie_state_e;

endpackage

// File: rtl/sreg_branch_eval.sv
// Branch condition evaluation on the registered status value (no forwarding).
module sreg_branch_eval (
  input  logic [7:0] sreg,
  input  logic [2:0] br_bit,
  input  logic       br_set,
  output logic       br_taken
);

  // Taken when the selected status bit matches the requested polarity.
  assign br_taken = (sreg[br_bit] == br_set);

endmodule

// File: rtl/status_reg.sv
// Status register {I,T,H,S,V,N,Z,C} with prioritised update sources and an
// interrupt-enable tracker that delays interrupt acceptance by one commit
// after I is raised.
// Optional feature: define STATUS_REG_BRANCH_EN to add the br_bit/br_set
// inputs and the br_taken output.
module status_reg
  import status_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       alu_cf,
  input  logic       alu_zf,
  input  logic       alu_nf,
  input  logic       alu_vf,
  input  logic       alu_sf,
  input  logic       alu_hf,
  input  logic [5:0] flag_we,
  input  logic       bset,
  input  logic       bclr,
  input  logic [2:0] bit_sel,
  input  logic       bst,
  input  logic       bst_val,
  input  logic       io_we,
  input  logic [7:0] io_wdata,
  input  logic       reti,
  input  logic       irq_ack,
`ifdef STATUS_REG_BRANCH_EN
  input  logic [2:0] br_bit,
  input  logic       br_set,
  output logic       br_taken,
`endif
  output logic [7:0] sreg,
  output logic       int_en
);

  logic [7:0]           sreg_p1;
  logic [7:0]           sreg_nxt;
  logic [ALU_FLAGS-1:0] alu_flags;
  ie_state_e            ie_state_p1;
  ie_state_e            ie_nxt;

  // Gather the ALU flags in SREG bit order so flag_we indexes them directly.
  always_comb begin
    alu_flags         = '0;
    alu_flags[SREG_C] = alu_cf;
    alu_flags[SREG_Z] = alu_zf;
    alu_flags[SREG_N] = alu_nf;
    alu_flags[SREG_V] = alu_vf;
    alu_flags[SREG_S] = alu_sf;
    alu_flags[SREG_H] = alu_hf;
  end

  // Apply sources lowest priority first so each higher source overwrites
  // whatever a lower one wrote to the same bit.
  always_comb begin
    sreg_nxt = sreg_p1;
    for (int b = 0; b < ALU_FLAGS; b++) begin
      if (flag_we[b]) sreg_nxt[b] = alu_flags[b];
    end
    if (reti) sreg_nxt[SREG_I] = 1'b1;
    if (bst)  sreg_nxt[SREG_T] = bst_val;
    if (bset && !bclr)      sreg_nxt[bit_sel] = 1'b1;
    else if (bclr && !bset) sreg_nxt[bit_sel] = 1'b0;
    else if (bset && bclr)  sreg_nxt[bit_sel] = sreg_p1[bit_sel];
    if (io_we)   sreg_nxt = io_wdata;
    if (irq_ack) sreg_nxt[SREG_I] = 1'b0;
  end

  // Interrupt-enable tracker: a rising I arms, the following commit enables.
  always_comb begin
    ie_nxt = ie_state_p1;
    if (ce) begin
      if (!sreg_nxt[SREG_I]) begin
        ie_nxt = IE_OFF;
      end else begin
        case (ie_state_p1)
          IE_OFF:  ie_nxt = IE_ARM;
          IE_ARM:  ie_nxt = IE_ON;
          default: ie_nxt = IE_ON;
        endcase
      end
    end
  end

  // Commit boundary: status and tracker advance only on ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_p1     <= 8'h00;
      ie_state_p1 <= IE_OFF;
    end else if (ce) begin
      sreg_p1     <= sreg_nxt;
      ie_state_p1 <= ie_nxt;
    end
  end

  assign sreg   = sreg_p1;
  assign int_en = (ie_state_p1 == IE_ON);

`ifdef STATUS_REG_BRANCH_EN
  sreg_branch_eval u_branch (
    .sreg     (sreg_p1),
    .br_bit   (br_bit),
    .br_set   (br_set),
    .br_taken (br_taken)
  );
`endif

endmodule

// File: tb/tb_status_reg.sv
// Randomised bench for status_reg against a per-bit priority reference model.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       alu_cf, alu_zf, alu_nf, alu_vf, alu_sf, alu_hf;
  logic [5:0] flag_we;
  logic       bset, bclr;
  logic [2:0] bit_sel;
  logic       bst, bst_val;
  logic       io_we;
  logic [7:0] io_wdata;
  logic       reti, irq_ack;
  logic [7:0] sreg;
  logic       int_en;
`ifdef STATUS_REG_BRANCH_EN
  logic [2:0] br_bit;
  logic       br_set;
  logic       br_taken;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: status byte plus commits seen since I last rose.
  logic [7:0] m_sreg;
  int         m_age;

  always #5 clk = ~clk;

  status_reg dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_nf(alu_nf),
    .alu_vf(alu_vf), .alu_sf(alu_sf), .alu_hf(alu_hf),
    .flag_we(flag_we), .bset(bset), .bclr(bclr), .bit_sel(bit_sel),
    .bst(bst), .bst_val(bst_val), .io_we(io_we), .io_wdata(io_wdata),
    .reti(reti), .irq_ack(irq_ack),
`ifdef STATUS_REG_BRANCH_EN
    .br_bit(br_bit), .br_set(br_set), .br_taken(br_taken),
`endif
    .sreg(sreg), .int_en(int_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_int_en();
    return m_sreg[7] && (m_age >= 1);
  endfunction

  // Each bit is decided by the highest-priority source that claims it.
  function automatic logic [7:0] model_next(input logic [7:0] old);
    logic [7:0] nx;
    logic [5:0] alu;
    alu = {alu_hf, alu_sf, alu_vf, alu_nf, alu_zf, alu_cf};
    for (int b = 0; b < 8; b++) begin
      if (b == 7 && irq_ack)                 nx[b] = 1'b0;
      else if (io_we)                        nx[b] = io_wdata[b];
      else if ((bset || bclr) && bit_sel == 3'(b))
        nx[b] = (bset && bclr) ? old[b] : bset;
      else if (b == 6 && bst)                nx[b] = bst_val;
      else if (b == 7 && reti)               nx[b] = 1'b1;
      else if (b < 6 && flag_we[b])          nx[b] = alu[b];
      else                                   nx[b] = old[b];
    end
    return nx;
  endfunction

  task automatic idle_inputs();
    ce = 1'b0; {alu_cf, alu_zf, alu_nf, alu_vf, alu_sf, alu_hf} = '0;
    flag_we = '0; bset = 0; bclr = 0; bit_sel = '0; bst = 0; bst_val = 0;
    io_we = 0; io_wdata = '0; reti = 0; irq_ack = 0;
`ifdef STATUS_REG_BRANCH_EN
    br_bit = '0; br_set = 0;
`endif
  endtask

  task automatic check_state(input string tag);
    check({tag, ".sreg"}, 32'(sreg), 32'(m_sreg));
    check({tag, ".int_en"}, 32'(int_en), 32'(model_int_en()));
`ifdef STATUS_REG_BRANCH_EN
    check({tag, ".br_taken"}, 32'(br_taken), 32'(m_sreg[br_bit] == br_set));
`endif
  endtask

  // Advance one clock with the current inputs; returns at the next falling edge.
  task automatic tick();
    logic [7:0] nx;
    nx = model_next(m_sreg);
    @(posedge clk);
    if (rst_n && ce) begin
      if (!nx[7])             m_age = 0;
      else if (!m_sreg[7])    m_age = 0;
      else if (m_age < 2)     m_age = m_age + 1;
      m_sreg = nx;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0; m_sreg = 8'h00; m_age = 0;

    // Reset held with an all-flags commit attempted.
    @(negedge clk);
    ce = 1; flag_we = 6'h3F;
    {alu_cf, alu_zf, alu_nf, alu_vf, alu_sf, alu_hf} = '1;
    tick();
    check("rst.sreg", 32'(sreg), 32'h00);
    check("rst.int_en", 32'(int_en), 32'h0);
    rst_n = 1'b1;
    idle_inputs();
    ce = 1; flag_we = 6'h3F; alu_zf = 1; alu_cf = 1;
    tick();
    check("first_commit", 32'(sreg), 32'h03);

    // SEI then a 3-cycle stall: stays armed until the next commit.
    idle_inputs(); ce = 1; bset = 1; bit_sel = 3'd7;
    tick();
    check("sei.int_en", 32'(int_en), 32'h0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.int_en", 32'(int_en), 32'h0);
    end
    ce = 1;
    tick();
    check("after_commit.int_en", 32'(int_en), 32'h1);
    check("after_commit.sreg", 32'(sreg), 32'h83);

    // io_we beats bset and ALU; I rises so the tracker arms.
    idle_inputs(); ce = 1; irq_ack = 1; tick();   // clear I first
    idle_inputs(); ce = 1; io_we = 1; io_wdata = 8'hFF;
    bset = 1; bit_sel = 3'd0; flag_we = 6'h3F;
    tick();
    check("io_prio.sreg", 32'(sreg), 32'hFF);
    check("io_prio.int_en", 32'(int_en), 32'h0);
    idle_inputs(); ce = 1; tick();
    check("io_prio.armed", 32'(int_en), 32'h1);

    // irq_ack with a same-cycle ALU update, then RETI re-arms.
    idle_inputs(); ce = 1; io_we = 1; io_wdata = 8'h80; tick();
    idle_inputs(); ce = 1; tick();
    check("setup80.sreg", 32'(sreg), 32'h80);
    check("setup80.int_en", 32'(int_en), 32'h1);
    idle_inputs(); ce = 1; irq_ack = 1; alu_nf = 1; flag_we = 6'h04;
    tick();
    check("irq_ack.sreg", 32'(sreg), 32'h04);
    check("irq_ack.int_en", 32'(int_en), 32'h0);
    idle_inputs(); ce = 1; reti = 1; tick();
    check("reti.sreg", 32'(sreg), 32'h84);
    check("reti.int_en", 32'(int_en), 32'h0);
    idle_inputs(); ce = 1; tick();
    check("reti.next", 32'(int_en), 32'h1);

    // bset+bclr on the same bit leaves it alone.
    idle_inputs(); ce = 1; io_we = 1; io_wdata = 8'h02; tick();
    idle_inputs(); ce = 1; bset = 1; bclr = 1; bit_sel = 3'd1; tick();
    check("bset_bclr", 32'(sreg), 32'h02);
`ifdef STATUS_REG_BRANCH_EN
    idle_inputs(); br_bit = 3'd1; br_set = 1; #1;
    check("br.z_set", 32'(br_taken), 32'h1);
    br_bit = 3'd0; br_set = 1; #1;
    check("br.c_set", 32'(br_taken), 32'h0);
    @(negedge clk);
`endif

    // Random commits with occasional asynchronous resets mid-cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      ce = ($urandom_range(0, 3) != 0);
      {alu_cf, alu_zf, alu_nf, alu_vf, alu_sf, alu_hf} = 6'($urandom);
      flag_we  = 6'($urandom);
      bset     = ($urandom_range(0, 5) == 0);
      bclr     = ($urandom_range(0, 5) == 0);
      bit_sel  = 3'($urandom);
      bst      = ($urandom_range(0, 5) == 0);
      bst_val  = 1'($urandom);
      io_we    = ($urandom_range(0, 9) == 0);
      io_wdata = 8'($urandom);
      reti     = ($urandom_range(0, 7) == 0);
      irq_ack  = ($urandom_range(0, 9) == 0);
`ifdef STATUS_REG_BRANCH_EN
      br_bit   = 3'($urandom);
      br_set   = 1'($urandom);
`endif
      if (cyc % 200 == 199) begin
        #2 rst_n = 1'b0;
        m_sreg = 8'h00; m_age = 0;
        #1;
        check("async_rst.sreg", 32'(sreg), 32'h00);
        check("async_rst.int_en", 32'(int_en), 32'h0);
        tick();
        check_state("held_rst");
        rst_n = 1'b1;
      end else begin
        tick();
        check_state("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
